aliens_ctrl_latch: RTL and testbench

- Control-register and watchdog stage directly downstream of the Aliens main-CPU address-decode PAL.
- Consumes the PAL's active-low control-register select, which decodes to 0x5F88 in the CPU map.
- Consumes the CPU write strobe and data bus, latches the control byte, and drives the outputs that depend on it: coin counters (pulse-stretched), palette/work-RAM bank select, and K052109 RMRD.
- Also hosts the CPU watchdog, which is kicked by its own decoded select.

---
 rtl/aliens_ctrl_latch.sv | 132 +++++++++++++
 tb/tb_aliens_ctrl_latch.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aliens_ctrl_latch.sv
// aliens_ctrl_latch: control register at 0x5F88 (coin counters, palette/work-RAM
// bank, K052109 RMRD) and the main-CPU watchdog.
// Build option: define ALIENS_CTRL_WDOG_EN to include the watchdog; without it
// wdog_rst_n is tied high and wdog_cs_n / wd_cen are ignored.
module aliens_ctrl_latch #(
  parameter int          COIN_MIN   = 16,
  parameter logic [19:0] WDOG_LIMIT = 20'd600000,
  parameter int          WDOG_HOLD  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_cen,
  input  logic       ctrl_cs_n,
  input  logic       wdog_cs_n,
  input  logic       cpu_wr_n,
  input  logic [7:0] cpu_din,
  input  logic       wd_cen,
  output logic [7:0] ctrl_q,
  output logic [1:0] coin_cnt,
  output logic       pal_bank,
  output logic       rmrd,
  output logic       wdog_rst_n
);

  localparam int SCW = $clog2(COIN_MIN) + 1;

  // Bus strobe semantics: a select/strobe counts only on cycles where cpu_cen
  // is high; an access is recognised once, on the first such cycle it is seen,
  // and the previous-state register advances only on cpu_cen cycles, so a
  // strobe held across many bus cycles yields exactly one event.
  logic wr_act;
  logic wr_prev;
  logic wr_stb;

  assign wr_act = cpu_cen & ~ctrl_cs_n & ~cpu_wr_n;
  assign wr_stb = wr_act & ~wr_prev;

  // Write edge detect and control-byte latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_prev <= 1'b0;
      ctrl_q  <= 8'h00;
    end else begin
      if (cpu_cen) wr_prev <= wr_act;
      if (wr_stb)  ctrl_q  <= cpu_din;
    end
  end

  // Bank select and RMRD are plain taps of the latched byte
  assign pal_bank = ctrl_q[5];
  assign rmrd     = ctrl_q[6];

  logic [1:0]     ctrl_prev;
  logic [SCW-1:0] sc [2];

  // Coin counters: a rising control bit starts a stretch window of COIN_MIN
  // clocks; inside the window the output is forced high and new edges are
  // ignored, afterwards the output simply follows the control bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_prev <= 2'b00;
      coin_cnt  <= 2'b00;
      for (int i = 0; i < 2; i++) sc[i] <= '0;
    end else begin
      ctrl_prev <= ctrl_q[1:0];
      for (int i = 0; i < 2; i++) begin
        if (sc[i] != '0) begin
          sc[i]       <= sc[i] - 1'b1;
          coin_cnt[i] <= 1'b1;
        end else if (ctrl_q[i] && !ctrl_prev[i]) begin
          sc[i]       <= SCW'(COIN_MIN - 1);
          coin_cnt[i] <= 1'b1;
        end else begin
          coin_cnt[i] <= ctrl_q[i];
        end
      end
    end
  end

`ifdef ALIENS_CTRL_WDOG_EN
  localparam int HCW = $clog2(WDOG_HOLD) + 1;

  logic           kick_act;
  logic           kick_prev;
  logic           kick;
  logic [19:0]    wc;
  logic [HCW-1:0] hc;
  logic           wdog_q;

  // Any access to the watchdog select kicks, read or write
  assign kick_act = cpu_cen & ~wdog_cs_n;
  assign kick     = kick_act & ~kick_prev;

  // Watchdog: count line ticks, fire after WDOG_LIMIT quiet ticks, then hold
  // the reset request low for WDOG_HOLD clocks. During the hold both ticks and
  // kicks are ignored; a kick beats a tick in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kick_prev <= 1'b0;
      wc        <= 20'd0;
      hc        <= '0;
      wdog_q    <= 1'b1;
    end else begin
      if (cpu_cen) kick_prev <= kick_act;
      if (hc != '0) begin
        hc <= hc - 1'b1;
        wc <= 20'd0;
        if (hc == HCW'(1)) wdog_q <= 1'b1;
      end else if (kick) begin
        wc <= 20'd0;
      end else if (wd_cen) begin
        if (wc == WDOG_LIMIT - 20'd1) begin
          wc     <= 20'd0;
          hc     <= HCW'(WDOG_HOLD);
          wdog_q <= 1'b0;
        end else begin
          wc <= wc + 20'd1;
        end
      end
    end
  end

  assign wdog_rst_n = wdog_q;
`else
  logic unused_wdog;

  // Watchdog inputs have no function in this build
  assign unused_wdog = wdog_cs_n ^ wd_cen;
  assign wdog_rst_n  = 1'b1;
`endif

endmodule

// File: tb/tb_aliens_ctrl_latch.sv
// tb_aliens_ctrl_latch: directed bench for the control latch, coin stretch and
// watchdog (watchdog scenarios follow the ALIENS_CTRL_WDOG_EN build option).
module tb_aliens_ctrl_latch;

  localparam int          COIN_MIN   = 16;
  localparam logic [19:0] WDOG_LIMIT = 20'd10;
  localparam int          WDOG_HOLD  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_cen;
  logic       ctrl_cs_n;
  logic       wdog_cs_n;
  logic       cpu_wr_n;
  logic [7:0] cpu_din;
  logic       wd_cen;
  logic [7:0] ctrl_q;
  logic [1:0] coin_cnt;
  logic       pal_bank;
  logic       rmrd;
  logic       wdog_rst_n;

  int tests_run    = 0;
  int tests_failed = 0;

  // Clock and reset
  always #5 clk = ~clk;

  aliens_ctrl_latch #(
    .COIN_MIN   (COIN_MIN),
    .WDOG_LIMIT (WDOG_LIMIT),
    .WDOG_HOLD  (WDOG_HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_cen    (cpu_cen),
    .ctrl_cs_n  (ctrl_cs_n),
    .wdog_cs_n  (wdog_cs_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_din    (cpu_din),
    .wd_cen     (wd_cen),
    .ctrl_q     (ctrl_q),
    .coin_cnt   (coin_cnt),
    .pal_bank   (pal_bank),
    .rmrd       (rmrd),
    .wdog_rst_n (wdog_rst_n)
  );

  // Driver tasks: inputs change on the falling edge, outputs are read there too
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_ctrl(input logic sel, input logic [7:0] d);
    ctrl_cs_n = ~sel;
    cpu_wr_n  = ~sel;
    cpu_din   = d;
  endtask

  task automatic bus_idle();
    cpu_cen   = 1'b1;
    wdog_cs_n = 1'b1;
    wd_cen    = 1'b0;
    drive_ctrl(1'b0, 8'h00);
  endtask

  task automatic apply_reset();
    bus_idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus_idle();
    rst_n = 1'b0;
    step();
    step();
    tests_run++;
    if (ctrl_q !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ctrl_q got %h want %h", ctrl_q, 8'h00);
    end
    tests_run++;
    if (coin_cnt !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_coin got %b want %b", coin_cnt, 2'b00);
    end
    tests_run++;
    if (pal_bank !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pal_bank got %b want 0", pal_bank);
    end
    tests_run++;
    if (rmrd !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rmrd got %b want 0", rmrd);
    end
    tests_run++;
    if (wdog_rst_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_wdog got %b want 1", wdog_rst_n);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_60();
    drive_ctrl(1'b1, 8'h60);
    tests_run++;
    if (ctrl_q !== 8'h00) begin
      tests_failed++;
      $display("FAIL wr60_before_edge got %h want %h", ctrl_q, 8'h00);
    end
    step();
    drive_ctrl(1'b0, 8'h00);
    tests_run++;
    if (ctrl_q !== 8'h60) begin
      tests_failed++;
      $display("FAIL wr60_ctrl_q got %h want %h", ctrl_q, 8'h60);
    end
    tests_run++;
    if (pal_bank !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr60_pal_bank got %b want 1", pal_bank);
    end
    tests_run++;
    if (rmrd !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr60_rmrd got %b want 1", rmrd);
    end
    tests_run++;
    if (coin_cnt !== 2'b00) begin
      tests_failed++;
      $display("FAIL wr60_coin got %b want %b", coin_cnt, 2'b00);
    end
    repeat (3) step();
    tests_run++;
    if (ctrl_q !== 8'h60 || coin_cnt !== 2'b00) begin
      tests_failed++;
      $display("FAIL wr60_idle ctrl_q %h coin %b want 60 00", ctrl_q, coin_cnt);
    end
  endtask

  task automatic test_hold_strobe();
    // Strobe held 10 clks, cpu_cen on odd clks only (5 bus cycles)
    for (int i = 0; i < 10; i++) begin
      cpu_cen = (i % 2 == 1);
      drive_ctrl(1'b1, (i == 0) ? 8'hAA : ((i == 1) ? 8'h01 : 8'h02));
      step();
      if (i == 0) begin
        tests_run++;
        if (ctrl_q !== 8'h60) begin
          tests_failed++;
          $display("FAIL hold_no_cen got %h want %h", ctrl_q, 8'h60);
        end
      end
    end
    cpu_cen = 1'b1;
    drive_ctrl(1'b0, 8'h00);
    step();
    tests_run++;
    if (ctrl_q !== 8'h01) begin
      tests_failed++;
      $display("FAIL hold_single_write got %h want %h", ctrl_q, 8'h01);
    end
    // Clear the register and let the coin stretch expire
    drive_ctrl(1'b1, 8'h00);
    step();
    drive_ctrl(1'b0, 8'h00);
    repeat (20) step();
    tests_run++;
    if (ctrl_q !== 8'h00 || coin_cnt !== 2'b00) begin
      tests_failed++;
      $display("FAIL hold_clear ctrl_q %h coin %b want 00 00", ctrl_q, coin_cnt);
    end
  endtask

  task automatic test_coin_stretch();
    int hi_cnt;
    int first_hi;
    int last_hi;
    int hi1_cnt;
    hi_cnt   = 0;
    first_hi = -1;
    last_hi  = -1;
    hi1_cnt  = 0;
    // Write 01 at edge 1, 00 at edge 3; coin[0] expected high after edges 2..17
    for (int k = 1; k <= 30; k++) begin
      case (k)
        1:       drive_ctrl(1'b1, 8'h01);
        3:       drive_ctrl(1'b1, 8'h00);
        default: drive_ctrl(1'b0, 8'h00);
      endcase
      step();
      if (coin_cnt[0]) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = k;
        last_hi = k;
      end
      if (coin_cnt[1]) hi1_cnt++;
    end
    tests_run++;
    if (first_hi != 2) begin
      tests_failed++;
      $display("FAIL stretch_rise got edge %0d want 2", first_hi);
    end
    tests_run++;
    if (last_hi != 17) begin
      tests_failed++;
      $display("FAIL stretch_last got edge %0d want 17", last_hi);
    end
    tests_run++;
    if (hi_cnt != COIN_MIN) begin
      tests_failed++;
      $display("FAIL stretch_len got %0d want %0d", hi_cnt, COIN_MIN);
    end
    tests_run++;
    if (hi1_cnt != 0) begin
      tests_failed++;
      $display("FAIL stretch_ch1_quiet got %0d want 0", hi1_cnt);
    end
  endtask

  task automatic test_coin_retoggle();
    int hi0;
    int hi1;
    int last0;
    hi0   = 0;
    hi1   = 0;
    last0 = -1;
    // 03, 00, 03, 00: the second rise lies inside the window and must not reload
    for (int k = 1; k <= 30; k++) begin
      case (k)
        1, 5:    drive_ctrl(1'b1, 8'h03);
        3, 7:    drive_ctrl(1'b1, 8'h00);
        default: drive_ctrl(1'b0, 8'h00);
      endcase
      step();
      if (coin_cnt[0]) begin
        hi0++;
        last0 = k;
      end
      if (coin_cnt[1]) hi1++;
    end
    tests_run++;
    if (hi0 != COIN_MIN) begin
      tests_failed++;
      $display("FAIL retoggle_ch0_len got %0d want %0d", hi0, COIN_MIN);
    end
    tests_run++;
    if (hi1 != COIN_MIN) begin
      tests_failed++;
      $display("FAIL retoggle_ch1_len got %0d want %0d", hi1, COIN_MIN);
    end
    tests_run++;
    if (last0 != 17) begin
      tests_failed++;
      $display("FAIL retoggle_last got edge %0d want 17", last0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    // Write 63 at edge 1 (stretch on both coins), ticks 1..10 fire the watchdog
    // at edge 10, reset at edge 12 lands inside both the stretch and the hold.
    for (int k = 1; k <= 13; k++) begin
      drive_ctrl(k == 1, 8'h63);
      wd_cen = (k <= 10);
      rst_n  = (k != 12);
      step();
      if (k == 11) begin
        tests_run++;
        if (coin_cnt !== 2'b11) begin
          tests_failed++;
          $display("FAIL midrst_pre_coin got %b want %b", coin_cnt, 2'b11);
        end
`ifdef ALIENS_CTRL_WDOG_EN
        tests_run++;
        if (wdog_rst_n !== 1'b0) begin
          tests_failed++;
          $display("FAIL midrst_pre_wdog got %b want 0", wdog_rst_n);
        end
`endif
      end
      if (k == 12) begin
        tests_run++;
        if (ctrl_q !== 8'h00 || pal_bank !== 1'b0 || rmrd !== 1'b0) begin
          tests_failed++;
          $display("FAIL midrst_ctrl got ctrl_q %h pal %b rmrd %b want 00 0 0", ctrl_q, pal_bank, rmrd);
        end
        tests_run++;
        if (coin_cnt !== 2'b00) begin
          tests_failed++;
          $display("FAIL midrst_coin got %b want %b", coin_cnt, 2'b00);
        end
        tests_run++;
        if (wdog_rst_n !== 1'b1) begin
          tests_failed++;
          $display("FAIL midrst_wdog got %b want 1", wdog_rst_n);
        end
      end
      if (k == 13) begin
        tests_run++;
        if (coin_cnt !== 2'b00 || wdog_rst_n !== 1'b1) begin
          tests_failed++;
          $display("FAIL midrst_after coin %b wdog %b want 00 1", coin_cnt, wdog_rst_n);
        end
      end
    end
    bus_idle();
    rst_n = 1'b1;
  endtask

`ifdef ALIENS_CTRL_WDOG_EN
  task automatic test_wdog_fire();
    int low_cnt;
    int first_low;
    int falls;
    logic prev;
    int low_at_100;
    apply_reset();
    low_cnt    = 0;
    first_low  = -1;
    falls      = 0;
    prev       = 1'b1;
    low_at_100 = 0;
    // Tick every 5 clks, no kicks except one inside the first hold
    for (int k = 1; k <= 110; k++) begin
      wd_cen    = (k % 5 == 0);
      wdog_cs_n = (k != 52);
      step();
      if (!wdog_rst_n) begin
        low_cnt++;
        if (first_low < 0) first_low = k;
        if (prev) falls++;
        if (k == 100) low_at_100 = 1;
      end
      prev = wdog_rst_n;
    end
    bus_idle();
    tests_run++;
    if (first_low != 50) begin
      tests_failed++;
      $display("FAIL wdog_first_fire got edge %0d want 50", first_low);
    end
    tests_run++;
    if (low_cnt != 2 * WDOG_HOLD) begin
      tests_failed++;
      $display("FAIL wdog_hold_len got %0d want %0d", low_cnt, 2 * WDOG_HOLD);
    end
    tests_run++;
    if (falls != 2) begin
      tests_failed++;
      $display("FAIL wdog_fire_count got %0d want 2", falls);
    end
    tests_run++;
    if (low_at_100 != 1) begin
      tests_failed++;
      $display("FAIL wdog_second_fire got %0d want 1", low_at_100);
    end
  endtask

  task automatic test_wdog_kick();
    int low_early;
    int first_low;
    apply_reset();
    low_early = 0;
    first_low = -1;
    // Tick every 2 clks, kick on every 5th tick (coincident) up to edge 120,
    // plus a control write at edge 120 alongside the kick.
    for (int k = 1; k <= 150; k++) begin
      wd_cen    = (k % 2 == 0);
      wdog_cs_n = !((k % 10 == 0) && (k <= 120));
      drive_ctrl(k == 120, 8'h40);
      step();
      if (!wdog_rst_n) begin
        if (k < 140) low_early++;
        if (first_low < 0) first_low = k;
      end
      if (k == 120) begin
        tests_run++;
        if (ctrl_q !== 8'h40 || rmrd !== 1'b1) begin
          tests_failed++;
          $display("FAIL kick_and_write ctrl_q %h rmrd %b want 40 1", ctrl_q, rmrd);
        end
      end
    end
    bus_idle();
    tests_run++;
    if (low_early != 0) begin
      tests_failed++;
      $display("FAIL kick_no_fire got %0d low clks want 0", low_early);
    end
    tests_run++;
    if (first_low != 140) begin
      tests_failed++;
      $display("FAIL kick_wins_tick got fire edge %0d want 140", first_low);
    end
  endtask
`else
  task automatic test_no_wdog();
    int bad;
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      wd_cen    = 1'b1;
      wdog_cs_n = ((k % 8) < 4);
      step();
      if (wdog_rst_n !== 1'b1) bad++;
    end
    bus_idle();
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL no_wdog_tied got %0d low clks want 0", bad);
    end
  endtask
`endif

  // Sequence and final report
  initial begin
    rst_n = 1'b0;
    bus_idle();
    test_reset();
    test_write_60();
    test_hold_strobe();
    test_coin_stretch();
    test_coin_retoggle();
    test_reset_mid();
`ifdef ALIENS_CTRL_WDOG_EN
    test_wdog_fire();
    test_wdog_kick();
`else
    test_no_wdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
